// File: rtl/fuse_load_ctrl.sv
// Fuse-to-trim loader: reads eight fuse words, verifies them and commits them atomically to trim_data.
// Define FUSE_CHKSUM_EN to require word7 == XOR(words 0..6); otherwise every load commits.
module fuse_load_ctrl #(
    parameter int RD_WAIT   = 4,
    parameter int RETRY_MAX = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fuse_auto_load_start,
    input  logic        sw_reload,
    input  logic [7:0]  fuse_rd_data,
    output logic        fuse_rd_en,
    output logic [2:0]  fuse_addr,
    output logic [63:0] trim_data,
    output logic        fuse_load_busy,
    output logic        fuse_load_done,
    output logic        fuse_load_err,
    output logic        init_err_cnt_flg
);

    // state      | meaning
    // ST_IDLE    | waiting for the first start edge after reset
    // ST_RD_REQ  | one-cycle read strobe for fuse word fuse_addr
    // ST_RD_WAIT | access wait, data captured on the last cycle
    // ST_CHK     | staging check; commit or retry/fail
    // ST_DONE    | trim committed, waiting for a reload request
    // ST_ERR     | retries exhausted, waiting for a reload request
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);
    localparam logic [2:0] RETRY_LIM = 3'(RETRY_MAX);

    state_t      r_state;
    state_t      w_next;
    logic        r_start_d;
    logic [3:0]  r_wait_cnt;
    logic [2:0]  r_addr;
    logic [2:0]  r_retry_cnt;
    logic [63:0] r_stage;
    logic [63:0] r_trim;
    logic        r_err_flg;

    logic        w_start_edge;
    logic        w_reload;
    logic        w_wait_tc;
    logic        w_chk_pass;

    assign w_start_edge = fuse_auto_load_start & ~r_start_d;
    assign w_reload     = w_start_edge | sw_reload;
    assign w_wait_tc    = (r_wait_cnt == 4'd0);

`ifdef FUSE_CHKSUM_EN
    assign w_chk_pass = (r_stage[63:56] == (r_stage[7:0]   ^ r_stage[15:8]  ^ r_stage[23:16] ^
                                            r_stage[31:24] ^ r_stage[39:32] ^ r_stage[47:40] ^
                                            r_stage[55:48]));
`else
    assign w_chk_pass = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_edge) w_next = ST_RD_REQ;
            ST_RD_REQ:  w_next = ST_RD_WAIT;
            ST_RD_WAIT: if (w_wait_tc) w_next = (r_addr == 3'd7) ? ST_CHK : ST_RD_REQ;
            ST_CHK: begin
                if (w_chk_pass)                  w_next = ST_DONE;
                else if (r_retry_cnt < RETRY_LIM) w_next = ST_RD_REQ;
                else                             w_next = ST_ERR;
            end
            ST_DONE,
            ST_ERR:     if (w_reload) w_next = ST_RD_REQ;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b0;
            r_wait_cnt  <= 4'd0;
            r_addr      <= 3'd0;
            r_retry_cnt <= 3'd0;
            r_stage     <= 64'd0;
            r_trim      <= 64'd0;
            r_err_flg   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_d <= fuse_auto_load_start;
            r_err_flg <= (r_state == ST_CHK) && !w_chk_pass;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_addr      <= 3'd0;
                        r_retry_cnt <= 3'd0;
                    end
                end
                ST_RD_REQ: r_wait_cnt <= WAIT_LOAD;
                ST_RD_WAIT: begin
                    if (w_wait_tc) begin
                        r_stage[{r_addr, 3'b000} +: 8] <= fuse_rd_data;
                        // natural 3-bit wrap returns the address to 0 after word 7
                        r_addr <= r_addr + 3'd1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_CHK: begin
                    if (w_chk_pass) r_trim      <= r_stage;
                    else            r_retry_cnt <= r_retry_cnt + 3'd1;
                end
                ST_DONE,
                ST_ERR: begin
                    if (w_reload) begin
                        r_addr      <= 3'd0;
                        r_retry_cnt <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fuse_rd_en       = (r_state == ST_RD_REQ);
    assign fuse_addr        = r_addr;
    assign trim_data        = r_trim;
    assign fuse_load_busy   = (r_state == ST_RD_REQ) || (r_state == ST_RD_WAIT) || (r_state == ST_CHK);
    assign fuse_load_done   = (r_state == ST_DONE);
    assign fuse_load_err    = (r_state == ST_ERR);
    assign init_err_cnt_flg = r_err_flg;

endmodule
